// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : handshake bundle between the core datapath and pipe_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              jump_en_i;
   logic [ADDR_W-1:0] jump_addr_i;
   logic              ex_busy_i;
   logic              ld_use_i;
   logic              halt_req_i;
   logic              pc_hold_o;
   logic              pc_load_o;
   logic [ADDR_W-1:0] pc_load_addr_o;
   logic              if_id_hold_o;
   logic              if_id_flush_o;
   logic              id_ex_hold_o;
   logic              id_ex_flush_o;
   logic              halted_o;
   logic              stall_timeout_o;
   logic [31:0]       stall_cyc_o;
   logic [31:0]       flush_evt_o;
   logic [31:0]       bubble_cnt_o;

   modport master (
      output jump_en_i, jump_addr_i, ex_busy_i, ld_use_i, halt_req_i,
      input  pc_hold_o, pc_load_o, pc_load_addr_o, if_id_hold_o, if_id_flush_o,
             id_ex_hold_o, id_ex_flush_o, halted_o, stall_timeout_o,
             stall_cyc_o, flush_evt_o, bubble_cnt_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, ex_busy_i, ld_use_i, halt_req_i,
      output pc_hold_o, pc_load_o, pc_load_addr_o, if_id_hold_o, if_id_flush_o,
             id_ex_hold_o, id_ex_flush_o, halted_o, stall_timeout_o,
             stall_cyc_o, flush_evt_o, bubble_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : hold/flush/redirect sequencing for the 3-stage core pipeline
// Optional perf counters: define PIPE_CTRL_PERF_EN.          Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int STALL_MAX    = 32,
   parameter int ADDR_W       = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   pipe_ctrl_if.slave  bus
);
   localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int c_STALL_W = $clog2(STALL_MAX + 1);
   localparam logic [c_FLUSH_W-1:0] c_FLUSH_LOAD = c_FLUSH_W'(FLUSH_CYCLES - 1);
   localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);
   localparam logic [c_STALL_W-1:0] c_STALL_MAX  = c_STALL_W'(STALL_MAX);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                r_state;
   logic [c_FLUSH_W-1:0]  r_flush_cnt;
   logic [c_STALL_W-1:0]  r_stall_cnt;
   logic                  r_halted;
   logic                  r_timeout;

   state_t                w_state_nxt;
   logic [c_FLUSH_W-1:0]  w_flush_nxt;
   logic [c_STALL_W-1:0]  w_stall_nxt;
   logic                  w_pc_hold, w_pc_load, w_if_id_hold, w_if_id_flush;
   logic                  w_id_ex_hold, w_id_ex_flush;
   logic [ADDR_W-1:0]     w_load_addr;
   logic                  w_busy_evt, w_jump_evt, w_bubble_evt;

   // Priority chain: HALT swallows everything, then busy > jump > flush > ld_use > halt.
   always_comb begin
      w_state_nxt   = r_state;
      w_flush_nxt   = r_flush_cnt;
      w_stall_nxt   = '0;
      w_pc_hold     = 1'b0;
      w_pc_load     = 1'b0;
      w_if_id_hold  = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_hold  = 1'b0;
      w_id_ex_flush = 1'b0;
      w_load_addr   = '0;
      w_busy_evt    = 1'b0;
      w_jump_evt    = 1'b0;
      w_bubble_evt  = 1'b0;
      if (rst) begin
         w_state_nxt = S_RUN;
         w_flush_nxt = '0;
      end else if (r_state == S_HALT) begin
         if (bus.halt_req_i) begin
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_flush = 1'b1;
         end else begin
            w_state_nxt = S_RUN;
         end
      end else if (bus.ex_busy_i) begin
         w_pc_hold    = 1'b1;
         w_if_id_hold = 1'b1;
         w_id_ex_hold = 1'b1;
         w_busy_evt   = 1'b1;
         w_state_nxt  = S_STALL;
         w_flush_nxt  = '0;
         w_stall_nxt  = (r_stall_cnt == c_STALL_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
      end else if (bus.jump_en_i) begin
         w_pc_load     = 1'b1;
         w_load_addr   = bus.jump_addr_i;
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         w_jump_evt    = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = c_FLUSH_LOAD;
         end else begin
            w_state_nxt = S_RUN;
         end
      end else if (r_state == S_FLUSH) begin
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         if (r_flush_cnt <= c_FLUSH_ONE) begin
            w_state_nxt = S_RUN;
            w_flush_nxt = '0;
         end else begin
            w_flush_nxt = r_flush_cnt - 1'b1;
         end
      end else begin
         w_state_nxt = S_RUN;
         if (bus.ld_use_i) begin
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_flush = 1'b1;
            w_bubble_evt  = 1'b1;
         end else if (bus.halt_req_i) begin
            w_state_nxt = S_HALT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_flush_cnt <= '0;
         r_stall_cnt <= '0;
         r_halted    <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_stall_cnt <= w_stall_nxt;
         r_halted    <= (r_state == S_HALT) && bus.halt_req_i;
         if (w_busy_evt && (w_stall_nxt == c_STALL_MAX)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign bus.pc_hold_o       = w_pc_hold;
   assign bus.pc_load_o       = w_pc_load;
   assign bus.pc_load_addr_o  = w_load_addr;
   assign bus.if_id_hold_o    = w_if_id_hold;
   assign bus.if_id_flush_o   = w_if_id_flush;
   assign bus.id_ex_hold_o    = w_id_ex_hold;
   assign bus.id_ex_flush_o   = w_id_ex_flush;
   assign bus.halted_o        = r_halted;
   assign bus.stall_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cyc;
   logic [31:0] r_flush_evt;
   logic [31:0] r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cyc  <= '0;
         r_flush_evt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_busy_evt)   r_stall_cyc  <= r_stall_cyc + 32'd1;
         if (w_jump_evt)   r_flush_evt  <= r_flush_evt + 32'd1;
         if (w_bubble_evt) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign bus.stall_cyc_o  = r_stall_cyc;
   assign bus.flush_evt_o  = r_flush_evt;
   assign bus.bubble_cnt_o = r_bubble_cnt;
`else
   assign bus.stall_cyc_o  = '0;
   assign bus.flush_evt_o  = '0;
   assign bus.bubble_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed + random bench for pipe_ctrl against a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
   localparam int c_FC = 2;
   localparam int c_SM = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipe_ctrl_if #(.ADDR_W(32)) bus ();

   pipe_ctrl #(.FLUSH_CYCLES(c_FC), .STALL_MAX(c_SM), .ADDR_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining flush cycles, consecutive busy count, halt mode.
   bit          m_halt_mode;
   int          m_flush_left;
   int          m_busy_run;
   bit          m_timeout;
   bit          m_halted;
   logic [31:0] m_stall_cyc, m_flush_evt, m_bubble;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_halt_mode  = 0;
      m_flush_left = 0;
      m_busy_run   = 0;
      m_timeout    = 0;
      m_halted     = 0;
      m_stall_cyc  = '0;
      m_flush_evt  = '0;
      m_bubble     = '0;
   endtask

   task automatic step(input bit r, input bit j, input logic [31:0] a,
                       input bit b, input bit l, input bit h);
      bit          e_pch, e_load, e_ifh, e_iff, e_idh, e_idf;
      logic [31:0] e_addr;
      @(negedge clk);
      rst             = r;
      bus.jump_en_i   = j;
      bus.jump_addr_i = a;
      bus.ex_busy_i   = b;
      bus.ld_use_i    = l;
      bus.halt_req_i  = h;
      #1;
      {e_pch, e_load, e_ifh, e_iff, e_idh, e_idf} = '0;
      e_addr = '0;
      if (r) begin
      end else if (m_halt_mode) begin
         if (h) {e_pch, e_ifh, e_idf} = 3'b111;
      end else if (b) begin
         {e_pch, e_ifh, e_idh} = 3'b111;
      end else if (j) begin
         {e_load, e_iff, e_idf} = 3'b111;
         e_addr = a;
      end else if (m_flush_left > 0) begin
         {e_iff, e_idf} = 2'b11;
      end else if (l) begin
         {e_pch, e_ifh, e_idf} = 3'b111;
      end
      chk("pc_hold",     32'(bus.pc_hold_o),       32'(e_pch));
      chk("pc_load",     32'(bus.pc_load_o),       32'(e_load));
      chk("pc_addr",     bus.pc_load_addr_o,       e_addr);
      chk("if_id_hold",  32'(bus.if_id_hold_o),    32'(e_ifh));
      chk("if_id_flush", 32'(bus.if_id_flush_o),   32'(e_iff));
      chk("id_ex_hold",  32'(bus.id_ex_hold_o),    32'(e_idh));
      chk("id_ex_flush", 32'(bus.id_ex_flush_o),   32'(e_idf));
      chk("halted",      32'(bus.halted_o),        32'(m_halted));
      chk("timeout",     32'(bus.stall_timeout_o), 32'(m_timeout));
      chk("hold_load_excl", 32'(bus.pc_hold_o & bus.pc_load_o), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk("stall_cyc",  bus.stall_cyc_o,  m_stall_cyc);
      chk("flush_evt",  bus.flush_evt_o,  m_flush_evt);
      chk("bubble_cnt", bus.bubble_cnt_o, m_bubble);
`else
      chk("stall_cyc",  bus.stall_cyc_o,  32'd0);
      chk("flush_evt",  bus.flush_evt_o,  32'd0);
      chk("bubble_cnt", bus.bubble_cnt_o, 32'd0);
`endif
      // Advance the model to what the coming edge should leave behind.
      if (r) begin
         model_reset();
      end else if (m_halt_mode) begin
         m_halted    = h;
         m_halt_mode = h;
         m_busy_run  = 0;
      end else begin
         m_halted = 0;
         if (b) begin
            m_busy_run   = (m_busy_run < c_SM) ? m_busy_run + 1 : c_SM;
            if (m_busy_run >= c_SM) m_timeout = 1;
            m_flush_left = 0;
            m_stall_cyc  = m_stall_cyc + 32'd1;
         end else begin
            m_busy_run = 0;
            if (j) begin
               m_flush_left = c_FC - 1;
               m_flush_evt  = m_flush_evt + 32'd1;
            end else if (m_flush_left > 0) begin
               m_flush_left--;
            end else if (l) begin
               m_bubble = m_bubble + 32'd1;
            end else if (h) begin
               m_halt_mode = 1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      bit rr, jj, bb, ll, hh;
      total = 0;
      bad   = 0;
      rst             = 1'b1;
      bus.jump_en_i   = 1'b0;
      bus.jump_addr_i = '0;
      bus.ex_busy_i   = 1'b0;
      bus.ld_use_i    = 1'b0;
      bus.halt_req_i  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      step(1, 0, 32'h0, 0, 0, 0);
      idle(1);

      // Jump with two flush cycles
      step(0, 1, 32'h0000_0100, 0, 0, 0);
      idle(3);

      // Busy swallows a jump; first free jump redirects
      step(0, 0, 32'h0, 1, 0, 0);
      step(0, 1, 32'hDEAD_0000, 1, 0, 0);
      step(0, 0, 32'h0, 1, 0, 0);
      step(0, 1, 32'h0000_0200, 0, 0, 0);
      idle(3);

      // Load-use bubble
      step(0, 0, 32'h0, 0, 1, 0);
      idle(2);

      // Watchdog: six busy cycles, flag stays sticky until reset
      repeat (6) step(0, 0, 32'h0, 1, 0, 0);
      idle(3);
      step(1, 0, 32'h0, 0, 0, 0);
      idle(2);

      // Halt for five cycles
      repeat (5) step(0, 0, 32'h0, 0, 0, 1);
      idle(3);

      // Halt deferred while flushing, then jump inside FLUSH reloads
      step(0, 1, 32'h0000_0300, 0, 0, 0);
      repeat (4) step(0, 0, 32'h0, 0, 0, 1);
      idle(2);
      step(0, 1, 32'h0000_0400, 0, 0, 0);
      step(0, 1, 32'h0000_0500, 0, 0, 0);
      idle(3);

      // Reset in the middle of a stall run, then a fresh run of four
      repeat (3) step(0, 0, 32'h0, 1, 0, 0);
      step(1, 0, 32'h0, 1, 0, 0);
      repeat (3) step(0, 0, 32'h0, 1, 0, 0);
      chk("timeout_restart", 32'(bus.stall_timeout_o), 32'd0);
      step(0, 0, 32'h0, 1, 0, 0);
      idle(2);
      step(1, 0, 32'h0, 0, 0, 0);

      // Random traffic
      hh = 0;
      for (int i = 0; i < 600; i++) begin
         rr = ($urandom_range(0, 79) == 0);
         jj = ($urandom_range(0, 5) == 0);
         bb = ($urandom_range(0, 4) == 0);
         ll = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 5) == 0) hh = ~hh;
         step(rr, jj, $urandom, bb, ll, hh);
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 3-stage core (pc/if_id → id → id_ex → ex).
- Turns branch/jump redirects, multi-cycle EX stalls, load-use hazards and debug halt requests into hold/flush controls for pc, if_id and id_ex.
- Drives the pc redirect.
- Small FSM with a flush counter and a stall watchdog; one place owns all pipeline sequencing.

Parameters:
- FLUSH_CYCLES, 2, cycles if_id/id_ex flush stays asserted after a redirect (legal range ≥1)
- STALL_MAX, 32, consecutive ex_busy_i cycles before stall_timeout_o sets
- ADDR_W, 32, pc width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- jump_en_i  in  1  taken branch/jump from ex
- jump_addr_i  in  ADDR_W  redirect target
- ex_busy_i  in  1  multi-cycle op occupying ex
- ld_use_i  in  1  id source matches pending load rd in ex
- halt_req_i  in  1  debug halt request (level)
- pc_hold_o  out  1  freeze pc
- pc_load_o  out  1  load pc from pc_load_addr_o
- pc_load_addr_o  out  ADDR_W  redirect target
- if_id_hold_o  out  1  freeze if_id
- if_id_flush_o  out  1  clear if_id to NOP
- id_ex_hold_o  out  1  freeze id_ex
- id_ex_flush_o  out  1  clear id_ex to NOP (reg_wen=0)
- halted_o  out  1  core halted (registered)
- stall_timeout_o  out  1  sticky watchdog flag (registered)

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high.
- While rst=1:
  - All outputs are 0 and pc_load_addr_o is 0.
  - State = RUN, and flush_cnt and stall_cnt are 0.
  - halted_o and stall_timeout_o clear at the edge.
- Control outputs (hold/flush/load) are combinational from state and inputs, and take effect at the next edge. halted_o and stall_timeout_o are registered.
- States: RUN, FLUSH, STALL, HALT.
- Event priority in every state: ex_busy_i > jump_en_i > ld_use_i > halt_req_i.
- ex_busy_i=1 (any state except HALT):
  - pc_hold_o, if_id_hold_o and id_ex_hold_o are all 1.
  - Next state is STALL, and stall_cnt increments, saturating at STALL_MAX.
  - stall_cnt reaching STALL_MAX sets stall_timeout_o. Only rst clears it.
  - jump_en_i is ignored while busy.
- STALL with ex_busy_i=0: stall_cnt clears, then the cycle is treated as RUN (the same-cycle jump/ld_use/halt is honoured).
- jump_en_i=1, not busy (RUN, FLUSH or STALL exit):
  - pc_load_o=1 and pc_load_addr_o=jump_addr_i.
  - if_id_flush_o=1 and id_ex_flush_o=1.
  - If FLUSH_CYCLES>1: next state is FLUSH with flush_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- FLUSH:
  - if_id_flush_o and id_ex_flush_o stay 1, flush_cnt decrements, and the FSM returns to RUN when flush_cnt reaches 1 at the edge.
  - A new jump_en_i in FLUSH reloads the counter and redirects to the new address.
  - ld_use_i and halt_req_i are ignored in FLUSH; halt is deferred.
- ld_use_i=1 in RUN:
  - pc_hold_o=1, if_id_hold_o=1 and id_ex_flush_o=1 for that cycle (one bubble).
  - State stays RUN.
- halt_req_i=1 in RUN with no higher event:
  - Next state is HALT.
  - In HALT: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1, and halted_o=1 from the first HALT cycle's edge onward.
- HALT with halt_req_i=0:
  - Next state is RUN and halted_o clears at that edge.
  - Holds deassert in the same cycle halt_req_i falls.
  - jump_en_i, ld_use_i and ex_busy_i are ignored in HALT. ex is drained by the flushes.
- pc_load_o and pc_hold_o are never both 1. When a load occurs, hold is 0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN
- Defined: adds outputs stall_cyc_o[31:0], flush_evt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cyc_o counts ex_busy stall cycles.
  - flush_evt_o counts accepted redirects.
  - bubble_cnt_o counts ld_use bubbles.
  - All three wrap at 2^32 and clear on rst.
- Undefined: these ports are still present but tied to 0, with no counter logic.

Test Plan:
- Jump, FLUSH_CYCLES=2: jump_en_i=1, jump_addr_i=0x0000_0100 for one cycle.
  - That cycle: pc_load_o=1, pc_load_addr_o=0x100, both flushes 1.
  - Next cycle: both flushes 1, pc_load_o=0.
  - Cycle after: all 0, state RUN.
- Busy + jump: ex_busy_i=1 for 3 cycles with jump_en_i=1 on the middle cycle.
  - All three holds are 1 for all 3 cycles, and pc_load_o stays 0 throughout.
  - When ex_busy_i falls, the first free jump_en_i produces the redirect.
- Load-use: ld_use_i=1 for 1 cycle.
  - pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1, id_ex_hold_o=0.
  - Next cycle: all 0.
- Watchdog, STALL_MAX=4: ex_busy_i=1 for 6 cycles.
  - stall_timeout_o rises after the 4th cycle and stays 1 after busy drops.
  - Only rst clears it.
- Halt: halt_req_i raised for 5 cycles, plus a jump in FLUSH.
  - During the halt: halted_o=1 one edge after entry, and holds stay 1 until halt_req_i falls.
  - Separately: halt_req_i raised while in FLUSH is deferred until FLUSH ends.
- Reset mid-STALL: rst=1 during ex_busy_i=1 with stall_cnt=3.
  - All outputs are 0 in that cycle and the state is RUN.
  - stall_cnt restarts from 0 on the next busy cycle.
